// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and state encoding for the miniLA pipeline hazard controller.
package pipe_ctrl_pkg;

    // RF write-data source code meaning "data comes from the RAM load path"
    localparam logic [2:0] WD_SEL_RAM = 3'b010;

    // Default number of MEM_WAIT cycles tolerated before the access is abandoned
    localparam int WAIT_MAX_DEF = 8;

    // Sequencer states: normal flow, or frozen waiting on the data bus
    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } pipe_state_e;

endpackage

// File: rtl/load_use_detect.sv
// Detects a load in EX whose destination is read by the instruction sitting in ID.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] rR1,
    input  logic [4:0] rR2,
    input  logic       re1,
    input  logic       re2,
    input  logic       rf_we,
    input  logic [2:0] wd_sel,
    input  logic [4:0] wR,
    output logic       load_use
);

    logic is_load;
    logic src_hit;

    // A hazard needs a real load to a non-zero register that ID actually reads
    always_comb begin
        is_load  = rf_we && (wd_sel == WD_SEL_RAM) && (wR != 5'd0);
        src_hit  = (re1 && (rR1 == wR)) || (re2 && (rR2 == wR));
        load_use = is_load && src_hit;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer: load-use bubbles, branch flushes, MEM bus-wait freeze
// with timeout, and a saturating count of PC-stall cycles.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = WAIT_MAX_DEF,
    parameter int CNT_W    = 16
) (
    input  logic             cpu_clk,
    input  logic             cpu_rst,
    input  logic [4:0]       IF_ID_rR1,
    input  logic [4:0]       IF_ID_rR2,
    input  logic             IF_ID_re1,
    input  logic             IF_ID_re2,
    input  logic             ID_EX_rf_we,
    input  logic [2:0]       ID_EX_rf_wd_sel,
    input  logic [4:0]       ID_EX_wR,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             stall_id_ex,
    output logic             stall_ex_mem,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_mem_wb,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int               WC_W      = $clog2(WAIT_MAX + 1);
    localparam logic [WC_W-1:0]  WC_ONE    = WC_W'(1);
    localparam logic [WC_W-1:0]  WAIT_LAST = WC_W'(WAIT_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

    pipe_state_e      state_q, state_d;
    logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    logic load_use;
    logic timeout;
    logic freeze;

    load_use_detect u_load_use_detect (
        .rR1      (IF_ID_rR1),
        .rR2      (IF_ID_rR2),
        .re1      (IF_ID_re1),
        .re2      (IF_ID_re2),
        .rf_we    (ID_EX_rf_we),
        .wd_sel   (ID_EX_rf_wd_sel),
        .wR       (ID_EX_wR),
        .load_use (load_use)
    );

    // Wait FSM: enter MEM_WAIT on an unacknowledged access, leave on ack or timeout
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout    = 1'b0;
        freeze     = 1'b0;
        case (state_q)
            ST_RUN: begin
                freeze = mem_req && !mem_ack;
                if (freeze) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = WC_ONE;
                end
            end
            ST_MEM_WAIT: begin
                timeout = (wait_cnt_q == WAIT_LAST) && !mem_ack;
                freeze  = !mem_ack && !timeout;
                if (mem_ack || timeout) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WC_ONE;
                end
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
        mem_err_d = timeout;
    end

    // Priority mux: freeze beats branch redirect beats load-use; silent in reset
    always_comb begin
        stall_pc     = 1'b0;
        stall_if_id  = 1'b0;
        stall_id_ex  = 1'b0;
        stall_ex_mem = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_mem_wb = 1'b0;
        if (!cpu_rst) begin
            if (freeze) begin
                stall_pc     = 1'b1;
                stall_if_id  = 1'b1;
                stall_id_ex  = 1'b1;
                stall_ex_mem = 1'b1;
                flush_mem_wb = 1'b1;
            end else if (ex_branch_taken) begin
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end else if (load_use) begin
                stall_pc    = 1'b1;
                stall_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end
        end
    end

    // Perf counter counts PC-stall cycles and sticks at all-ones
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall_pc && (stall_cycles_q != CNT_SAT)) begin
            stall_cycles_d = stall_cycles_q + CNT_ONE;
        end
    end

    // State, wait counter, error pulse and perf counter registers
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_q        <= ST_RUN;
            wait_cnt_q     <= '0;
            mem_err_q      <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            mem_err_q      <= mem_err_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign mem_err      = mem_err_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a model.
module tb_pipe_hazard_ctrl;

   localparam int WAIT_MAX = 8;
   localparam int CNT_W    = 16;

   logic             cpu_clk = 1'b0;
   logic             cpu_rst;
   logic [4:0]       IF_ID_rR1, IF_ID_rR2, ID_EX_wR;
   logic             IF_ID_re1, IF_ID_re2, ID_EX_rf_we;
   logic [2:0]       ID_EX_rf_wd_sel;
   logic             ex_branch_taken, mem_req, mem_ack;
   logic             stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
   logic             flush_if_id, flush_id_ex, flush_mem_wb, mem_err;
   logic [CNT_W-1:0] stall_cycles;
   logic [6:0]       outs;

   int checks   = 0;
   int failures = 0;

   pipe_hazard_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
      .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
      .IF_ID_rR1(IF_ID_rR1), .IF_ID_rR2(IF_ID_rR2),
      .IF_ID_re1(IF_ID_re1), .IF_ID_re2(IF_ID_re2),
      .ID_EX_rf_we(ID_EX_rf_we), .ID_EX_rf_wd_sel(ID_EX_rf_wd_sel), .ID_EX_wR(ID_EX_wR),
      .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ack(mem_ack),
      .stall_pc(stall_pc), .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex),
      .stall_ex_mem(stall_ex_mem), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
      .flush_mem_wb(flush_mem_wb), .mem_err(mem_err), .stall_cycles(stall_cycles)
   );

   always #5 cpu_clk = ~cpu_clk;

   // Output bundle: {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id, flush_id_ex, flush_mem_wb}
   assign outs = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id, flush_id_ex, flush_mem_wb};

   // One comparison: counts it and reports a mismatch on a single line
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Drive one cycle of inputs just after the rising edge
   task automatic applyStimulus(input logic rst, input logic [4:0] r1, input logic [4:0] r2,
                                input logic e1, input logic e2, input logic we,
                                input logic [2:0] sel, input logic [4:0] wr,
                                input logic br, input logic req, input logic ack);
      @(posedge cpu_clk);
      #1;
      cpu_rst = rst;        IF_ID_rR1 = r1;     IF_ID_rR2 = r2;
      IF_ID_re1 = e1;       IF_ID_re2 = e2;     ID_EX_rf_we = we;
      ID_EX_rf_wd_sel = sel; ID_EX_wR = wr;     ex_branch_taken = br;
      mem_req = req;        mem_ack = ack;
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   // Behavioural reference: age of the outstanding bus access, pending error, stall tally
   int          m_age = 0;
   bit          m_err = 1'b0;
   int unsigned m_cnt = 0;

   initial begin : model_compare
      logic       lu, frozen, tmo;
      logic [6:0] exp_outs;
      forever begin
         @(negedge cpu_clk);
         if (cpu_rst === 1'b1) begin
            m_age = 0;
            m_err = 1'b0;
            m_cnt = 0;
         end
         lu = ID_EX_rf_we && ID_EX_rf_wd_sel == 3'b010 && ID_EX_wR != 5'd0 &&
              ((IF_ID_re1 && IF_ID_rR1 == ID_EX_wR) || (IF_ID_re2 && IF_ID_rR2 == ID_EX_wR));
         if (m_age == 0) begin
            tmo    = 1'b0;
            frozen = mem_req && !mem_ack;
         end else begin
            tmo    = (m_age == WAIT_MAX - 1) && !mem_ack;
            frozen = !mem_ack && !tmo;
         end
         if (cpu_rst === 1'b1)     exp_outs = 7'b0000000;
         else if (frozen)          exp_outs = 7'b1111001;
         else if (ex_branch_taken) exp_outs = 7'b0000110;
         else if (lu)              exp_outs = 7'b1100010;
         else                      exp_outs = 7'b0000000;
         checkOutput("model_outs", 32'(outs), 32'(exp_outs));
         checkOutput("model_mem_err", 32'(mem_err), 32'(m_err));
         checkOutput("model_stall_cycles", 32'(stall_cycles), m_cnt);
         if (cpu_rst !== 1'b1) begin
            if (m_age == 0)               m_age = frozen ? 1 : 0;
            else if (mem_ack || tmo)      m_age = 0;
            else                          m_age = m_age + 1;
            m_err = tmo;
            if (exp_outs[6] && m_cnt < (2 ** CNT_W) - 1) m_cnt = m_cnt + 1;
         end
      end
   end

   // Directed scenarios with hand-derived values, then random traffic, then saturation
   initial begin : stimulus
      cpu_rst = 1'b1; IF_ID_rR1 = '0; IF_ID_rR2 = '0; IF_ID_re1 = 1'b0; IF_ID_re2 = 1'b0;
      ID_EX_rf_we = 1'b0; ID_EX_rf_wd_sel = '0; ID_EX_wR = '0;
      ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;

      applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      @(negedge cpu_clk);
      checkOutput("reset_outs", 32'(outs), 32'h0);
      checkOutput("reset_cnt", 32'(stall_cycles), 32'h0);
      checkOutput("reset_err", 32'(mem_err), 32'h0);

      applyStimulus(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 3'b010, 5'd5, 1'b0, 1'b0, 1'b0);
      @(negedge cpu_clk);
      checkOutput("lu_rs1", 32'(outs), 32'h62);
      idleCycle();
      @(negedge cpu_clk);
      checkOutput("lu_release", 32'(outs), 32'h0);
      checkOutput("lu_cnt", 32'(stall_cycles), 32'd1);

      applyStimulus(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 3'b010, 5'd0, 1'b0, 1'b0, 1'b0);
      @(negedge cpu_clk);
      checkOutput("lu_wr0", 32'(outs), 32'h0);
      applyStimulus(1'b0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 3'b010, 5'd5, 1'b0, 1'b0, 1'b0);
      @(negedge cpu_clk);
      checkOutput("lu_re1_off", 32'(outs), 32'h0);
      applyStimulus(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 3'b000, 5'd5, 1'b0, 1'b0, 1'b0);
      @(negedge cpu_clk);
      checkOutput("lu_alu", 32'(outs), 32'h0);
      applyStimulus(1'b0, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 3'b010, 5'd5, 1'b0, 1'b0, 1'b0);
      @(negedge cpu_clk);
      checkOutput("lu_rs2", 32'(outs), 32'h62);

      applyStimulus(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 3'b010, 5'd5, 1'b1, 1'b0, 1'b0);
      @(negedge cpu_clk);
      checkOutput("branch_over_lu", 32'(outs), 32'h06);
      checkOutput("branch_cnt_before", 32'(stall_cycles), 32'd2);
      idleCycle();
      @(negedge cpu_clk);
      checkOutput("branch_cnt_after", 32'(stall_cycles), 32'd2);

      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0, (i == 1), 1'b1, 1'b0);
         @(negedge cpu_clk);
         checkOutput("wait_freeze", 32'(outs), 32'h79);
      end
      applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b1, 1'b1, 1'b1);
      @(negedge cpu_clk);
      checkOutput("wait_ack_branch", 32'(outs), 32'h06);
      applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b1, 1'b1);
      @(negedge cpu_clk);
      checkOutput("run_req_ack", 32'(outs), 32'h0);
      checkOutput("wait_cnt3", 32'(stall_cycles), 32'd5);
      applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      @(negedge cpu_clk);
      checkOutput("stray_ack", 32'(outs), 32'h0);

      for (int i = 0; i < WAIT_MAX - 1; i++) begin
         applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b1, 1'b0);
         @(negedge cpu_clk);
         checkOutput("tmo_freeze", 32'(outs), 32'h79);
      end
      applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      @(negedge cpu_clk);
      checkOutput("tmo_release", 32'(outs), 32'h0);
      checkOutput("tmo_err_not_yet", 32'(mem_err), 32'h0);
      checkOutput("tmo_cnt", 32'(stall_cycles), 32'd12);
      idleCycle();
      @(negedge cpu_clk);
      checkOutput("tmo_err_pulse", 32'(mem_err), 32'h1);
      idleCycle();
      @(negedge cpu_clk);
      checkOutput("tmo_err_clear", 32'(mem_err), 32'h0);

      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      end
      applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      @(negedge cpu_clk);
      checkOutput("rst_wait_outs", 32'(outs), 32'h0);
      checkOutput("rst_wait_cnt", 32'(stall_cycles), 32'h0);
      for (int i = 0; i < 2; i++) begin
         idleCycle();
         @(negedge cpu_clk);
         checkOutput("rst_wait_no_err", 32'(mem_err), 32'h0);
      end

      for (int i = 0; i < 3000; i++) begin
         applyStimulus(($urandom_range(0, 99) == 0),
                       5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)),
                       ($urandom_range(0, 1) == 1) ? 3'b010 : 3'($urandom_range(0, 7)),
                       5'($urandom_range(0, 3)),
                       ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) != 0),
                       ($urandom_range(0, 3) == 0));
      end

      applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < (2 ** CNT_W) + 4; i++) begin
         applyStimulus(1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 3'b010, 5'd7, 1'b0, 1'b0, 1'b0);
      end
      @(negedge cpu_clk);
      checkOutput("sat_value", 32'(stall_cycles), 32'h0000FFFF);
      idleCycle();
      @(negedge cpu_clk);
      checkOutput("sat_hold", 32'(stall_cycles), 32'h0000FFFF);

      @(negedge cpu_clk);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
